// File: rtl/mux_packer_pkg.sv
// mux_packer_pkg: shared constants, types and helpers for the byte-to-word packer.
//   BYTE_W         width of one incoming byte
//   BYTES_PER_WORD number of byte lanes in a packed word
//   WORD_W         packed word width
//   BE_W           byte-enable width (one bit per lane)
//   FILL_W         width of the lane fill counter (0..BYTES_PER_WORD-1)
//   ENTRY_W        FIFO entry width: {byte enables, word}
package mux_packer_pkg;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;
  localparam int BE_W           = 4;
  localparam int FILL_W         = 2;
  localparam int ENTRY_W        = WORD_W + BE_W;

  // What the assembly stage hands to the FIFO on a given edge.
  typedef enum logic [1:0] {
    PUSH_NONE    = 2'd0,
    PUSH_FULL    = 2'd1,
    PUSH_PARTIAL = 2'd2
  } push_kind_e;

  // Byte-enable mask with the lowest 'fill' lanes set (fill = 0..4).
  function automatic logic [BE_W-1:0] be_from_fill(input logic [FILL_W:0] fill);
    logic [BE_W-1:0] be;
    be = '0;
    for (int i = 0; i < BE_W; i++) begin
      if (i < int'(fill)) be[i] = 1'b1;
    end
    return be;
  endfunction

endpackage

// File: rtl/mux_packer_fifo.sv
// mux_packer_fifo: synchronous FIFO with first-word-fall-through read.
//   clk    rising-edge clock
//   rst    asynchronous active-high reset (pointers and count only)
//   push   write request; ignored when full unless a pop happens on the same edge
//   pop    read request; ignored when empty
//   wdata  entry to write
//   rdata  entry at the head; forced to zero while empty
//   full   DEPTH entries stored
//   empty  no entries stored
module mux_packer_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

  assign do_pop  = pop && !empty;
  // When full, a same-edge pop frees the slot; the write lands on the slot
  // being vacated, which is safe because the head is read before the edge.
  assign do_push = push && (!full || do_pop);

  // Head is visible combinationally so a pushed word is valid one edge later.
  assign rdata = empty ? '0 : mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

endmodule

// File: rtl/mux_packer.sv
// mux_packer: packs a byte stream little-endian into 32-bit words with byte
// enables, buffers them in a small FIFO and offers them on a valid/ready port.
//   clk                   rising-edge clock
//   rst                   asynchronous active-high reset
//   in_data               incoming byte
//   in_datavalid          qualifies in_data (no backpressure)
//   flush                 emit the partially filled word, if any
//   out_ready             downstream ready
//   out_word              packed word at the FIFO head
//   out_be                byte enables for out_word (bit i -> bits 8i+7:8i)
//   out_valid             FIFO non-empty
//   overflow              sticky: a word was dropped on a full FIFO
//   assertion_shengyushen inverse of overflow
module mux_packer
  import mux_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_datavalid,
  input  logic              flush,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [BE_W-1:0]   out_be,
  output logic              out_valid,
  output logic              overflow,
  output logic              assertion_shengyushen
);

  logic [FILL_W-1:0]  fill_reg;
  logic [FILL_W-1:0]  fill_next;
  logic [WORD_W-1:0]  asm_reg;
  logic [WORD_W-1:0]  asm_next;
  logic [WORD_W-1:0]  merged_word;
  logic [FILL_W:0]    fill_after;
  logic               overflow_reg;
  push_kind_e         push_kind;
  logic [BE_W-1:0]    push_be;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_rdata;

  // Current word with the incoming byte steered into the lane at the fill level.
  // Lanes above the fill level are always zero because asm_reg is cleared on push.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      assign merged_word[gi*BYTE_W +: BYTE_W] =
        (in_datavalid && (fill_reg == FILL_W'(gi))) ? in_data
                                                    : asm_reg[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  // Fill level once this edge's byte (if any) is included; flush acts on this.
  assign fill_after = {1'b0, fill_reg} + {{FILL_W{1'b0}}, in_datavalid};

  always_comb begin
    push_kind = PUSH_NONE;
    push_be   = '0;
    fill_next = fill_reg;
    asm_next  = asm_reg;
    // A completing byte takes priority so a same-cycle flush yields one full word.
    if (in_datavalid && (fill_reg == FILL_W'(BYTES_PER_WORD - 1))) begin
      push_kind = PUSH_FULL;
    end else if (flush && (fill_after != '0)) begin
      push_kind = PUSH_PARTIAL;
    end
    case (push_kind)
      PUSH_FULL: begin
        push_be   = '1;
        fill_next = '0;
        asm_next  = '0;
      end
      PUSH_PARTIAL: begin
        push_be   = be_from_fill(fill_after);
        fill_next = '0;
        asm_next  = '0;
      end
      default: begin
        if (in_datavalid) begin
          asm_next  = merged_word;
          fill_next = fill_reg + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_reg     <= '0;
      asm_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      fill_reg <= fill_next;
      asm_reg  <= asm_next;
      // The FIFO refuses a push into a full buffer without a same-edge pop.
      if (fifo_push && fifo_full && !fifo_pop) overflow_reg <= 1'b1;
    end
  end

  assign fifo_push = (push_kind != PUSH_NONE);
  assign fifo_pop  = out_valid && out_ready;

  mux_packer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({push_be, merged_word}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid             = !fifo_empty;
  assign out_word              = fifo_rdata[WORD_W-1:0];
  assign out_be                = fifo_rdata[ENTRY_W-1:WORD_W];
  assign overflow              = overflow_reg;
  assign assertion_shengyushen = !overflow_reg;

endmodule

// File: doc/mux_packer.md
MUX_PACKER -- requirements
Module: mux_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the number of 36-bit entries (32-bit word plus 4-bit byte enable); legal values are powers of two, 2 to 16.
REQ-002 Port clk  input  1  SHALL be the single rising-edge clock for all state.
REQ-003 Port rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 Port in_data  input  8  SHALL carry the byte stream from the upstream 7-stage delay pipeline.
REQ-005 Port in_datavalid  input  1  SHALL qualify in_data; there is no backpressure toward upstream.
REQ-006 Port flush  input  1  SHALL request emission of a partially filled word.
REQ-007 Port out_ready  input  1  SHALL be the downstream ready for the word handshake.
REQ-008 Port out_word  output  32  SHALL carry the packed word at the FIFO head.
REQ-009 Port out_be  output  4  SHALL carry byte enables for out_word, with bit i covering out_word[8i+7:8i].
REQ-010 Port out_valid  output  1  SHALL be high while the FIFO is non-empty.
REQ-011 Port overflow  output  1  SHALL be a sticky flag indicating at least one word was dropped.
REQ-012 Port assertion_shengyushen  output  1  SHALL equal !overflow, serving as the formal property output.

Function
REQ-013 Each valid byte SHALL be captured on a rising clk edge.
REQ-014 Captured bytes SHALL be placed little-endian: the first byte of a word goes to [7:0], the fourth to [31:24].
REQ-015 A 2-bit byte counter SHALL track the fill level (0..3) and wrap from 3 to 0 when a word completes.
REQ-016 When the edge captures the fourth byte, the completed word SHALL be pushed with out_be=4'b1111.
- If the FIFO was empty, out_valid SHALL be high immediately after that edge (latency 1 clock from the 4th byte presented).
REQ-017 When flush is high at an edge and the fill level is greater than 0, a partial word SHALL be pushed.
- out_be SHALL have one bit set per filled byte, e.g. 2 bytes gives 4'b0011.
- Unfilled byte lanes SHALL be 8'h00.
- The counter SHALL return to 0.
REQ-018 flush and in_datavalid high in the same cycle: the byte SHALL be included first, then flush applies.
- If that byte completes the word, a single full word (be=1111) SHALL be pushed, not two words.
REQ-019 flush with fill level 0 and in_datavalid low SHALL have no effect.
REQ-020 A pop SHALL occur at an edge where out_valid and out_ready are both high.
- out_word and out_be SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Push into a full FIFO without a simultaneous pop SHALL drop the word.
- overflow SHALL set to 1 and remain 1 until reset.
- FIFO contents SHALL be unchanged.
REQ-022 Simultaneous push and pop when full SHALL succeed with no overflow.
- Simultaneous push and pop when empty SHALL behave as a push only.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with a separate count to distinguish full from empty.

Reset
REQ-024 Asserting rst SHALL, without waiting for clk, clear the byte counter, assembly register, FIFO pointers and count, and overflow.
REQ-025 During reset the outputs SHALL be: out_valid=0, out_word=32'h0, out_be=4'h0, overflow=0, assertion_shengyushen=1.
REQ-026 Reset asserted mid-word SHALL discard the partial bytes and any queued words.
REQ-027 The first valid byte after reset deassertion SHALL land in lane 0.

Structure
REQ-028 Package mux_packer_pkg SHALL hold the shared constants:
- BYTE_W=8
- BYTES_PER_WORD=4
- WORD_W=32
- BE_W=4
REQ-029 The FIFO SHALL be a separate sub-module, mux_packer_fifo: synchronous, with push/pop/full/empty, parameterised by depth and width.
REQ-030 The assembly logic (counter, lane steering, flush) SHALL reside in mux_packer.

Verification
REQ-031 Bytes 11,22,33,44 on consecutive cycles with out_ready=1 -> one word 32'h44332211, be=1111, out_valid high 1 cycle after byte 44.
REQ-032 Bytes AA,BB, then flush alone -> word 32'h0000BBAA, be=0011; a following flush alone produces nothing.
REQ-033 Bytes 01,02,03, then 04 with flush in the same cycle -> exactly one word 32'h04030201, be=1111.
REQ-034 out_ready=0, 20 bytes 00..13 -> first 4 words held in order, 5th word dropped, overflow=1, assertion_shengyushen=0; then out_ready=1 -> words 03020100, 07060504, 0B0A0908, 0F0E0D0C popped in order.
REQ-035 FIFO full with out_ready=1 while a 4th byte completes a word -> pop and push in the same edge, count stays 4, overflow stays 0.
REQ-036 rst pulsed between two clk edges after 2 bytes -> outputs cleared immediately; next bytes 55,66,77,88 -> word 32'h88776655.
